// File: rtl/imm_gen_pipe.sv
// RISC-V RV32I/RV64I immediate generator feeding a 2-entry valid/ready buffer.
// The decoded {imm, fmt, illegal} is registered, so nothing passes combinationally from instr to imm.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;
  localparam bit         RV64     = (XLEN == 64);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t          r_state, w_state_next;
  logic            r_head, r_tail;
  logic            w_push, w_pop;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic            w_s;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt, w_shamt_w;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_ill;

  assign w_op       = instr[6:0];
  assign w_f3       = instr[14:12];
  assign w_s        = instr[31];
  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  assign w_imm_i = {{(XLEN-11){w_s}}, instr[30:20]};
  assign w_imm_s = {{(XLEN-11){w_s}}, instr[30:25], instr[11:7]};
  assign w_imm_b = {{(XLEN-12){w_s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){w_s}}, instr[30:12], 12'h000};
  assign w_imm_j = {{(XLEN-20){w_s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  // Word shifts and all RV32 shifts use a 5-bit shamt; RV64 OP-IMM shifts use 6 bits.
  assign w_shamt_w = {{(XLEN-5){1'b0}}, instr[24:20]};
  assign w_shamt   = RV64 ? {{(XLEN-6){1'b0}}, instr[25:20]} : w_shamt_w;

  always_comb begin
    w_fmt = FMT_NONE;
    w_imm = '0;
    w_ill = 1'b1;
    case (w_op)
      7'b0110111, 7'b0010111: begin w_fmt = FMT_U; w_imm = w_imm_u; w_ill = 1'b0; end
      7'b1101111:             begin w_fmt = FMT_J; w_imm = w_imm_j; w_ill = 1'b0; end
      7'b1100111, 7'b0000011, 7'b1110011: begin
        w_fmt = FMT_I; w_imm = w_imm_i; w_ill = 1'b0;
      end
      7'b0010011: begin
        w_fmt = FMT_I; w_ill = 1'b0;
        w_imm = w_is_shift ? w_shamt : w_imm_i;
      end
      7'b0011011: begin
        if (RV64) begin
          w_fmt = FMT_I; w_ill = 1'b0;
          w_imm = w_is_shift ? w_shamt_w : w_imm_i;
        end
      end
      7'b0100011: begin w_fmt = FMT_S; w_imm = w_imm_s; w_ill = 1'b0; end
      7'b1100011: begin w_fmt = FMT_B; w_imm = w_imm_b; w_ill = 1'b0; end
      7'b0110011: begin w_fmt = FMT_R; w_ill = 1'b0; end
      7'b0111011: begin
        if (RV64) begin
          w_fmt = FMT_R; w_ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = rst_n & (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_push) w_state_next = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_state_next = S_TWO;
        else if (w_pop && !w_push) w_state_next = S_EMPTY;
      end
      S_TWO:   if (w_pop) w_state_next = S_ONE;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [XLEN-1:0] r_imm;
      logic [2:0]      r_fmt;
      logic            r_ill;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_imm <= '0;
          r_fmt <= FMT_NONE;
          r_ill <= 1'b0;
        end else if (w_push && (r_tail == 1'(gi))) begin
          r_imm <= w_imm;
          r_fmt <= w_fmt;
          r_ill <= w_ill;
        end
      end
    end
  endgenerate

  assign imm     = r_head ? g_entry[1].r_imm : g_entry[0].r_imm;
  assign fmt     = r_head ? g_entry[1].r_fmt : g_entry[0].r_fmt;
  assign illegal = r_head ? g_entry[1].r_ill : g_entry[0].r_ill;

endmodule
